instr_fetch_responder: RTL and testbench
========================================

Name: instr_fetch_responder

Overview:
Responder side of the program-counter interface. It samples the current `pc`, issues a word read to instruction memory over a req/ack handshake, and presents the fetched instruction to decode with a valid/ready handshake. It pulses `pc_advance` back to the PC-next logic when an instruction is handed off. It sits between the program counter and the decode stage, and reports misaligned, out-of-range and timeout fetch faults.

Parameters:
- ADDR_W, 10, word-address width of instruction memory; reachable byte range is 0 .. 2^(ADDR_W+2)-1.
- TIMEOUT, 16, maximum cycles to wait for `mem_ack` before a timeout fault (≥2).

Ports:
- clk  in  1  system clock; all state updates on the rising edge (pc changes on the falling edge, so it is stable at each rising edge).
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- pc  in  32  current program counter (byte address).
- fetch_en  in  1  permits starting a new fetch.
- flush  in  1  abort current fetch and discard any pending instruction.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  ADDR_W  word address, equal to pc[ADDR_W+1:2].
- mem_ack  in  1  one-cycle read-complete strobe.
- mem_rdata  in  32  read data, valid when `mem_ack`=1.
- instr  out  32  fetched instruction.
- instr_pc  out  32  byte address of `instr`.
- instr_valid  out  1  `instr` is available to decode.
- instr_ready  in  1  decode accepts `instr`.
- pc_advance  out  1  one-cycle pulse on handoff; PC-next logic advances pc.
- fault  out  1  sticky fault flag.
- fault_cause  out  2  01 misaligned, 10 out-of-range, 11 timeout, 00 none.

Behaviour:
- Reset (reset=0, asynchronous):
  - State is IDLE.
  - `mem_req`, `mem_addr`, `instr`, `instr_pc`, `instr_valid`, `pc_advance`, `fault`, `fault_cause` and the wait counter are all 0.
- States: IDLE, REQ, HOLD, DRAIN, FAULT. All outputs are registered.
- IDLE, with `fetch_en`=1:
  - If pc[1:0]≠0: go to FAULT, cause 01.
  - Else if any pc bit above ADDR_W+1 is set: go to FAULT, cause 10.
  - Else: latch pc into `instr_pc`, set `mem_addr`=pc[ADDR_W+1:2], set `mem_req`=1, clear the counter, go to REQ.
  - Misaligned takes priority over out-of-range.
- IDLE, with `fetch_en`=0: stay in IDLE.
- REQ:
  - `mem_req` is held at 1 and `mem_addr` is held stable.
  - On `mem_ack`: capture `mem_rdata` into `instr`, set `instr_valid`=1, set `mem_req`=0, go to HOLD. Memory may ack in the first REQ cycle, giving a minimum of 2 cycles from sample to `instr_valid`.
  - Without `mem_ack`: the counter increments. When the counter reaches TIMEOUT-1 with no ack, set `mem_req`=0 and go to FAULT with cause 11.
- HOLD:
  - `instr_valid`=1; `instr` and `instr_pc` are held stable.
  - When `instr_ready`=1: pulse `pc_advance`=1 for exactly the next cycle, clear `instr_valid`, go to IDLE.
  - The new pc is sampled in IDLE one cycle after the pulse, which guarantees the negedge PC update has landed.
- FAULT:
  - `fault` stays at 1; `mem_req`=0; `instr_valid`=0.
  - Only `flush` exits FAULT, clearing `fault` and `fault_cause` and returning to IDLE.
- Flush (highest priority, evaluated at each rising edge):
  - `instr_valid` and `pc_advance` are forced to 0 next cycle.
  - In REQ with no `mem_ack` that cycle: set `mem_req`=0, clear the counter, go to DRAIN.
  - In REQ with `mem_ack` in the same cycle: discard the data, go to IDLE.
  - In HOLD or IDLE: go to IDLE, even if `instr_ready` is high in the same cycle (the instruction is discarded and there is no `pc_advance`).
- DRAIN:
  - `mem_req`=0. Wait for `mem_ack`, discard the data, then go to IDLE.
  - If TIMEOUT cycles pass without an ack, go to IDLE with no fault.
  - `flush` in DRAIN has no further effect.
- `mem_ack` is ignored in IDLE, HOLD and FAULT.
- `pc_advance` never asserts in any cycle in which `instr_valid` was not handshaked.

Test Plan:
1. Release reset, pc=0x00000010, fetch_en=1, memory acks in first REQ cycle with 0x00500093 -> mem_addr=4, instr_valid 2 cycles after sample, instr=0x00500093, instr_pc=0x10; instr_ready=1 -> pc_advance one-cycle pulse.
2. Hold instr_ready=0 for 5 cycles in HOLD -> instr/instr_valid stable, no pc_advance; then ready=1 -> single pulse, return to IDLE, next pc (0x14) sampled the following cycle.
3. pc=0x00000006 -> fault=1, cause 01, mem_req never asserts; pc=0x00001000 with ADDR_W=10 -> cause 10; flush clears fault to 0 and returns to IDLE.
4. Memory never acks, TIMEOUT=16 -> mem_req high exactly 16 cycles then drops; fault=1, cause 11.
5. flush in REQ cycle 2, ack arrives 3 cycles later with 0xDEADBEEF -> no instr_valid, no pc_advance, mem_req low during DRAIN, IDLE after ack; flush coincident with ack -> data dropped, IDLE directly.
6. Assert reset=0 mid-REQ and mid-HOLD -> all outputs 0 immediately (asynchronously); after release, normal fetch from the current pc.

Source files
------------

// File: rtl/instr_fetch_responder.sv
// ---------------------------------------------------------------------------
// instr_fetch_responder
//
// Fetches one instruction at a time from instruction memory on behalf of the
// program counter and hands it to decode.
//   1. Samples pc.
//   2. Issues a word read over a req/ack handshake.
//   3. Presents the result on a valid/ready handshake.
//   4. Pulses pc_advance when decode accepts the instruction.
// Misaligned, out-of-range and timed-out fetches raise a sticky fault that
// only flush clears.
//
// Ports:
//   clk          rising-edge system clock
//   reset        asynchronous active-low reset
//   pc           current program counter (byte address), stable at rising edges
//   fetch_en     permits starting a new fetch from IDLE
//   flush        aborts the current fetch / discards a pending instruction
//   mem_req      read request to instruction memory
//   mem_addr     word address, pc[ADDR_W+1:2]
//   mem_ack      one-cycle read-complete strobe
//   mem_rdata    read data, valid with mem_ack
//   instr        fetched instruction
//   instr_pc     byte address of instr
//   instr_valid  instr is available to decode
//   instr_ready  decode accepts instr
//   pc_advance   one-cycle pulse on handoff
//   fault        sticky fault flag
//   fault_cause  01 misaligned, 10 out-of-range, 11 timeout, 00 none
// ---------------------------------------------------------------------------
module instr_fetch_responder #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pc,
  input  logic              fetch_en,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              pc_advance,
  output logic              fault,
  output logic [1:0]        fault_cause
);

  // The counter only ever needs to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE    = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       instr_pc_q, instr_pc_d;
  logic              instr_valid_q, instr_valid_d;
  logic              pc_advance_q, pc_advance_d;
  logic              fault_q, fault_d;
  logic [1:0]        fault_cause_q, fault_cause_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic pc_misaligned;
  logic pc_out_of_range;

  assign pc_misaligned   = (pc[1:0] != 2'b00);
  // Any byte-address bit beyond the reachable word range.
  assign pc_out_of_range = ((pc >> (ADDR_W + 2)) != 32'd0);

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    pc_advance_d  = 1'b0;          // pulse: high for one cycle at most
    fault_d       = fault_q;
    fault_cause_d = fault_cause_q;
    cnt_d         = cnt_q;

    case (state_q)
      IDLE: begin
        // A flush while idle just holds us here for the cycle.
        if (!flush && fetch_en) begin
          if (pc_misaligned) begin
            state_d       = FAULT;
            fault_d       = 1'b1;
            fault_cause_d = CAUSE_MISALIGN;
          end else if (pc_out_of_range) begin
            state_d       = FAULT;
            fault_d       = 1'b1;
            fault_cause_d = CAUSE_RANGE;
          end else begin
            state_d    = REQ;
            instr_pc_d = pc;
            mem_addr_d = pc[ADDR_W+1:2];
            mem_req_d  = 1'b1;
            cnt_d      = '0;
          end
        end
      end

      REQ: begin
        if (flush) begin
          instr_valid_d = 1'b0;
          mem_req_d     = 1'b0;
          cnt_d         = '0;
          // An ack coincident with flush completes the read; nothing to drain.
          state_d       = mem_ack ? IDLE : DRAIN;
        end else if (mem_ack) begin
          instr_d       = mem_rdata;
          instr_valid_d = 1'b1;
          mem_req_d     = 1'b0;
          state_d       = HOLD;
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d     = 1'b0;
          fault_d       = 1'b1;
          fault_cause_d = CAUSE_TIMEOUT;
          state_d       = FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HOLD: begin
        if (flush) begin
          instr_valid_d = 1'b0;
          state_d       = IDLE;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
          pc_advance_d  = 1'b1;
          state_d       = IDLE;
        end
      end

      DRAIN: begin
        // The outstanding read must still complete (or time out) so its late
        // ack is not mistaken for the next fetch's data.
        if (mem_ack || (cnt_q == CNT_LAST)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      FAULT: begin
        mem_req_d     = 1'b0;
        instr_valid_d = 1'b0;
        if (flush) begin
          fault_d       = 1'b0;
          fault_cause_d = 2'b00;
          state_d       = IDLE;
        end
      end

      default: begin
        state_d       = IDLE;
        mem_req_d     = 1'b0;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      instr_valid_q <= 1'b0;
      pc_advance_q  <= 1'b0;
      fault_q       <= 1'b0;
      fault_cause_q <= 2'b00;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      pc_advance_q  <= pc_advance_d;
      fault_q       <= fault_d;
      fault_cause_q <= fault_cause_d;
      cnt_q         <= cnt_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign pc_advance  = pc_advance_q;
  assign fault       = fault_q;
  assign fault_cause = fault_cause_q;

endmodule

// File: tb/tb_instr_fetch_responder.sv
module tb_instr_fetch_responder;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       pc;
  logic              fetch_en;
  logic              flush;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic [31:0]       instr;
  logic [31:0]       instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              pc_advance;
  logic              fault;
  logic [1:0]        fault_cause;

  int checks = 0;
  int errors = 0;

  instr_fetch_responder #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .pc(pc), .fetch_en(fetch_en), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_advance(pc_advance), .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-22s observed %h expected %h", tag, obs, exp);
  endtask

  // Outputs are sampled and inputs driven at the falling edge.
  task automatic nedge();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi_cnt;
    reset = 1'b0; pc = 32'd0; fetch_en = 1'b0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'd0; instr_ready = 1'b0;

    // ---- reset state
    nedge(); nedge();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_valid_adv", {30'd0, instr_valid, pc_advance}, 32'd0);
    chk("rst_fault", {29'd0, fault, fault_cause}, 32'd0);

    // ---- test 1: basic fetch, ack in first REQ cycle
    reset = 1'b1; pc = 32'h10; fetch_en = 1'b1;
    nedge();
    chk("t1_req", {31'd0, mem_req}, 32'd1);
    chk("t1_addr", {22'd0, mem_addr}, 32'd4);
    chk("t1_instr_pc", instr_pc, 32'h10);
    chk("t1_valid_early", {31'd0, instr_valid}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h00500093;
    nedge();
    chk("t1_valid", {31'd0, instr_valid}, 32'd1);
    chk("t1_instr", instr, 32'h00500093);
    chk("t1_req_drop", {31'd0, mem_req}, 32'd0);
    mem_ack = 1'b0; instr_ready = 1'b1;
    nedge();
    chk("t1_pc_adv", {31'd0, pc_advance}, 32'd1);
    chk("t1_valid_clr", {31'd0, instr_valid}, 32'd0);
    instr_ready = 1'b0; pc = 32'h14;   // PC-next logic reacts to the pulse

    // ---- test 2: next pc sampled, decode stalls 5 cycles
    nedge();
    chk("t2_pc_adv_once", {31'd0, pc_advance}, 32'd0);
    chk("t2_req", {31'd0, mem_req}, 32'd1);
    chk("t2_addr", {22'd0, mem_addr}, 32'd5);
    chk("t2_instr_pc", instr_pc, 32'h14);
    mem_ack = 1'b1; mem_rdata = 32'h00A00113; fetch_en = 1'b0;
    nedge();
    mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t2_hold_valid%0d", i), {31'd0, instr_valid}, 32'd1);
      chk($sformatf("t2_hold_instr%0d", i), instr, 32'h00A00113);
      chk($sformatf("t2_hold_adv%0d", i), {31'd0, pc_advance}, 32'd0);
      nedge();
    end
    instr_ready = 1'b1;
    nedge();
    chk("t2_pc_adv", {31'd0, pc_advance}, 32'd1);
    instr_ready = 1'b0; pc = 32'h18;
    nedge();
    chk("t2_adv_clr", {31'd0, pc_advance}, 32'd0);
    chk("t2_idle_req", {31'd0, mem_req}, 32'd0);

    // ---- test 3: misaligned / out-of-range faults
    pc = 32'h6; fetch_en = 1'b1;
    nedge();
    fetch_en = 1'b0;
    chk("t3_mis_fault", {29'd0, fault, fault_cause}, 32'b101);
    chk("t3_mis_req", {31'd0, mem_req}, 32'd0);
    nedge(); nedge();
    chk("t3_sticky", {29'd0, fault, fault_cause}, 32'b101);
    chk("t3_sticky_req", {31'd0, mem_req}, 32'd0);
    flush = 1'b1;
    nedge();
    flush = 1'b0;
    chk("t3_flush_clr", {29'd0, fault, fault_cause}, 32'd0);
    pc = 32'h1000; fetch_en = 1'b1;
    nedge();
    fetch_en = 1'b0;
    chk("t3_range_fault", {29'd0, fault, fault_cause}, 32'b110);
    chk("t3_range_req", {31'd0, mem_req}, 32'd0);
    flush = 1'b1;
    nedge();
    flush = 1'b0;
    chk("t3_flush_clr2", {29'd0, fault, fault_cause}, 32'd0);
    pc = 32'h1002; fetch_en = 1'b1;   // both faults: misaligned wins
    nedge();
    fetch_en = 1'b0;
    chk("t3_priority", {29'd0, fault, fault_cause}, 32'b101);
    flush = 1'b1;
    nedge();
    flush = 1'b0;
    chk("t3_flush_clr3", {29'd0, fault, fault_cause}, 32'd0);

    // ---- test 4: timeout at the top reachable word
    pc = 32'hFFC; fetch_en = 1'b1;
    nedge();
    fetch_en = 1'b0;
    chk("t4_addr_max", {22'd0, mem_addr}, 32'h3FF);
    hi_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req) hi_cnt++;
      nedge();
    end
    chk("t4_req_cycles", hi_cnt, 32'd16);
    chk("t4_timeout", {29'd0, fault, fault_cause}, 32'b111);
    chk("t4_req_low", {31'd0, mem_req}, 32'd0);
    flush = 1'b1;
    nedge();
    flush = 1'b0;
    chk("t4_flush_clr", {29'd0, fault, fault_cause}, 32'd0);

    // ---- test 5a: flush in REQ cycle 2, late ack drained
    pc = 32'h20; fetch_en = 1'b1;
    nedge();
    fetch_en = 1'b0;
    chk("t5_req1", {31'd0, mem_req}, 32'd1);
    nedge();
    chk("t5_req2", {31'd0, mem_req}, 32'd1);
    flush = 1'b1;
    nedge();
    flush = 1'b0;
    chk("t5_drain_req0", {31'd0, mem_req}, 32'd0);
    nedge();
    chk("t5_drain_req1", {31'd0, mem_req}, 32'd0);
    nedge();
    chk("t5_drain_valid", {31'd0, instr_valid}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    nedge();
    mem_ack = 1'b0;
    chk("t5_drop_valid", {30'd0, instr_valid, pc_advance}, 32'd0);
    chk("t5_drop_instr", instr, 32'h00A00113);
    pc = 32'h24; fetch_en = 1'b1;
    nedge();
    fetch_en = 1'b0;
    chk("t5_idle_again", {31'd0, mem_req}, 32'd1);
    chk("t5_addr", {22'd0, mem_addr}, 32'd9);

    // ---- test 5b: flush coincident with ack
    mem_ack = 1'b1; flush = 1'b1; mem_rdata = 32'hCAFEF00D;
    nedge();
    mem_ack = 1'b0; flush = 1'b0;
    chk("t5b_valid", {30'd0, instr_valid, pc_advance}, 32'd0);
    chk("t5b_req", {31'd0, mem_req}, 32'd0);
    chk("t5b_instr", instr, 32'h00A00113);
    pc = 32'h28; fetch_en = 1'b1;
    nedge();
    fetch_en = 1'b0;
    chk("t5b_direct_idle", {22'd0, mem_addr}, 32'hA);
    chk("t5b_req_again", {31'd0, mem_req}, 32'd1);

    // ---- test 5c: flush beats instr_ready in HOLD
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    nedge();
    mem_ack = 1'b0;
    chk("t5c_valid", {31'd0, instr_valid}, 32'd1);
    instr_ready = 1'b1; flush = 1'b1;
    nedge();
    instr_ready = 1'b0; flush = 1'b0;
    chk("t5c_no_adv", {30'd0, instr_valid, pc_advance}, 32'd0);

    // ---- test 6: asynchronous reset mid-REQ and mid-HOLD
    pc = 32'h40; fetch_en = 1'b1;
    nedge();
    chk("t6_req", {31'd0, mem_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_req", {31'd0, mem_req}, 32'd0);
    chk("t6_async_addr", {22'd0, mem_addr}, 32'd0);
    chk("t6_async_pc", instr_pc, 32'd0);
    nedge();
    reset = 1'b1;
    nedge();
    chk("t6_refetch_addr", {22'd0, mem_addr}, 32'h10);
    mem_ack = 1'b1; mem_rdata = 32'h12345678; fetch_en = 1'b0;
    nedge();
    mem_ack = 1'b0;
    chk("t6_hold_valid", {31'd0, instr_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_valid", {31'd0, instr_valid}, 32'd0);
    chk("t6_async_instr", instr, 32'd0);
    nedge();
    reset = 1'b1; pc = 32'h44; fetch_en = 1'b1;
    nedge();
    fetch_en = 1'b0;
    chk("t6_post_addr", {22'd0, mem_addr}, 32'h11);
    chk("t6_post_pc", instr_pc, 32'h44);
    mem_ack = 1'b1; mem_rdata = 32'h00000009;
    nedge();
    mem_ack = 1'b0;
    chk("t6_post_instr", instr, 32'h9);
    instr_ready = 1'b1;
    nedge();
    instr_ready = 1'b0;
    chk("t6_post_adv", {31'd0, pc_advance}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
